// File: rtl/sram_arb_pkg.sv
// Shared types and default geometry for the single-port SRAM sequencer/arbiter.
package sram_arb_pkg;

  localparam int NPORT      = 2;
  localparam int ARB_ADDR_W = 12;
  localparam int ARB_DATA_W = 16;
  localparam int ARB_DEPTH  = 4096;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone eligible port wins, a tie goes to the port named by rr_i.
module rr_arb2 (
  input  logic [1:0] elig_i,
  input  logic       rr_i,
  input  logic       en_i,
  output logic [1:0] grant_o
);

  assign grant_o[0] = en_i & elig_i[0] & (~elig_i[1] | ~rr_i);
  assign grant_o[1] = en_i & elig_i[1] & (~elig_i[0] |  rr_i);

endmodule

// File: rtl/sram1rw_arbiter.sv
// Init sweep plus two-port round-robin sharing of one single-port SRAM macro,
// with posted writes and per-port read response channels.
import sram_arb_pkg::*;

module sram1rw_arbiter #(
  parameter int                 ADDR_W   = ARB_ADDR_W,
  parameter int                 DATA_W   = ARB_DATA_W,
  parameter int                 DEPTH    = ARB_DEPTH,
  parameter int                 INIT_EN  = 1,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPORT-1:0]        req_valid,
  output logic [NPORT-1:0]        req_ready,
  input  logic [NPORT-1:0]        req_we,
  input  logic [NPORT*ADDR_W-1:0] req_addr,
  input  logic [NPORT*DATA_W-1:0] req_wdata,
  output logic [NPORT-1:0]        rsp_valid,
  input  logic [NPORT-1:0]        rsp_ready,
  output logic [NPORT*DATA_W-1:0] rsp_rdata,
  output logic                    init_done,
  output logic                    sram_csb,
  output logic                    sram_web,
  output logic                    sram_oeb,
  output logic [ADDR_W-1:0]       sram_a,
  output logic [DATA_W-1:0]       sram_i,
  input  logic [DATA_W-1:0]       sram_o
);

  // Handshakes: a request transfers in a cycle where req_valid and req_ready are
  // both high; a response transfers in a cycle where rsp_valid and rsp_ready are
  // both high. req_ready is a same-cycle combinational grant.

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       icnt_q, icnt_d;
  logic                    rr_q, rr_d;
  logic [NPORT-1:0]        inflight_q, inflight_d;
  logic [NPORT-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NPORT*DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0]       a_q;
  logic [DATA_W-1:0]       i_q;

  logic                    in_init, in_run;
  logic [NPORT-1:0]        elig, grant;
  logic                    win, any_grant;
  logic [ADDR_W-1:0]       win_addr;
  logic [DATA_W-1:0]       win_wdata;
  logic                    win_we;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    if (state_q == ST_INIT) begin
      icnt_d = icnt_q + 1'b1;
      if (icnt_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end
    end
  end

  // Outputs are gated by rst_n so the macro is released the instant reset asserts.
  assign in_init   = rst_n & (state_q == ST_INIT);
  assign in_run    = rst_n & (state_q == ST_RUN);
  assign init_done = in_run;

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      elig[p] = req_valid[p] & (req_we[p] | ~(rsp_valid_q[p] | inflight_q[p]));
    end
  end

  rr_arb2 u_rr_arb2 (
    .elig_i  (elig),
    .rr_i    (rr_q),
    .en_i    (in_run),
    .grant_o (grant)
  );

  assign any_grant = |grant;
  assign win       = grant[1];
  assign win_addr  = win ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
  assign win_wdata = win ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
  assign win_we    = win ? req_we[1] : req_we[0];
  assign req_ready = grant;

  // Macro drive; address and data hold their last value on idle cycles.
  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_oeb = 1'b1;
    sram_a   = a_q;
    sram_i   = i_q;
    if (in_init) begin
      sram_csb = 1'b0;
      sram_web = 1'b0;
      sram_a   = icnt_q;
      sram_i   = INIT_VAL;
    end else if (any_grant) begin
      sram_csb = 1'b0;
      sram_a   = win_addr;
      if (win_we) begin
        sram_web = 1'b0;
        sram_i   = win_wdata;
      end else begin
        sram_oeb = 1'b0;
      end
    end
  end

  // Read pipeline and response channels
  always_comb begin
    rr_d        = any_grant ? ~win : rr_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    for (int p = 0; p < NPORT; p++) begin
      inflight_d[p] = grant[p] & ~req_we[p];
      if (inflight_q[p]) begin
        rsp_valid_d[p]              = 1'b1;
        rdata_d[p*DATA_W +: DATA_W] = sram_o;
      end else if (rsp_valid_q[p] && rsp_ready[p]) begin
        rsp_valid_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= 1'b0;
      inflight_q  <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      a_q         <= '0;
      i_q         <= '0;
    end else begin
      rr_q        <= rr_d;
      inflight_q  <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      a_q         <= sram_a;
      i_q         <= sram_i;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram1rw_arbiter.sv
// Bench for sram1rw_arbiter: behavioural macro, reference model of the arbiter and memory, scripted plus random traffic.
module tb_sram1rw_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int DEPTH = 4096;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata, rsp_rdata;
  logic          init_done, sram_csb, sram_web, sram_oeb;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_i, sram_o;

  sram1rw_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
    .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o)
  );

  // behavioural single-port macro, 1-cycle registered read
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web)      mem[sram_a] <= sram_i;
      else if (!sram_oeb) sram_o      <= mem[sram_a];
    end
  end

  // scoreboard / reference model
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [2][$];
  int   rd_st [2];   // 0 idle, 1 read accepted, 2 response pending
  logic m_rr;
  logic [1:0] m_g;
  bit   chk_on = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_cycle();
    logic [1:0] el;
    int w;
    for (int p = 0; p < 2; p++) el[p] = req_valid[p] && (req_we[p] || rd_st[p] == 0);
    m_g = 2'b00;
    if (el == 2'b11) m_g[m_rr] = 1'b1;
    else             m_g = el;
    check_eq("req_ready", 32'(req_ready), 32'(m_g));
    check_eq("rsp_valid", 32'(rsp_valid), 32'({rd_st[1] == 2, rd_st[0] == 2}));
    for (int p = 0; p < 2; p++)
      if (rd_st[p] == 2) check_eq("rsp_rdata", 32'(rsp_rdata[p*DW +: DW]), 32'(exp_q[p][0]));
    w = m_g[1] ? 1 : 0;
    if (m_g != 2'b00) begin
      check_eq("sram_cmd", 32'({sram_csb, sram_web, sram_oeb, sram_a}),
               32'({1'b0, ~req_we[w], req_we[w], req_addr[w*AW +: AW]}));
      if (req_we[w]) check_eq("sram_wdata", 32'(sram_i), 32'(req_wdata[w*DW +: DW]));
    end else begin
      check_eq("sram_idle", 32'({sram_csb, sram_web, sram_oeb}), 32'(3'b111));
    end
    // advance to the state after the coming edge
    for (int p = 0; p < 2; p++) begin
      if (rd_st[p] == 2 && rsp_ready[p]) begin
        rd_st[p] = 0;
        void'(exp_q[p].pop_front());
      end else if (rd_st[p] == 1) begin
        rd_st[p] = 2;
      end
    end
    if (m_g != 2'b00) begin
      if (req_we[w]) ref_mem[req_addr[w*AW +: AW]] = req_wdata[w*DW +: DW];
      else begin
        exp_q[w].push_back(ref_mem[req_addr[w*AW +: AW]]);
        rd_st[w] = 1;
      end
      m_rr = (w == 0);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
    if (chk_on) model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[p]         = v;
    req_we[p]            = we;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*DW +: DW] = d;
  endtask

  task automatic idle();
    req_valid = 2'b00;
  endtask

  task automatic req_once(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    drive(p, 1'b1, we, a, d);
    n = 0;
    do begin
      step();
      n++;
    end while (!m_g[p] && n < 20);
    if (!m_g[p]) check_eq("grant_timeout", 32'(req_ready[p]), 32'd1);
    req_valid[p] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
    for (int p = 0; p < 2; p++) rd_st[p] = 0;
    m_rr = 1'b0;
    m_g  = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ctrl", 32'({req_ready, rsp_valid, init_done, sram_csb, sram_web, sram_oeb}), 32'(8'b0000_0111));
    check_eq("rst_a", 32'(sram_a), 32'd0);
    check_eq("rst_i", 32'(sram_i), 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);

    // init sweep: one write per cycle, addresses 0..DEPTH-1 in order
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < DEPTH; k++) begin
      check_eq("init_sweep", 32'({req_ready, init_done, sram_csb, sram_web, sram_oeb, sram_a}),
               32'({2'b00, 1'b0, 3'b001, 12'(k)}));
      @(negedge clk);
    end
    check_eq("init_done", 32'(init_done), 32'd1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    chk_on = 1'b1;
    @(posedge clk);
    #1;

    // reads of the swept corners
    rsp_ready = 2'b11;
    req_once(0, 1'b0, 12'h000, '0);
    repeat (3) step();
    req_once(0, 1'b0, 12'hFFF, '0);
    repeat (3) step();

    // write then read back on port 0
    req_once(0, 1'b1, 12'h123, 16'hA5A5);
    req_once(0, 1'b0, 12'h123, '0);
    repeat (4) step();

    // both ports streaming reads of their own preloaded words
    req_once(0, 1'b1, 12'h010, 16'h1111);
    req_once(1, 1'b1, 12'h020, 16'h2222);
    drive(0, 1'b1, 1'b0, 12'h010, '0);
    drive(1, 1'b1, 1'b0, 12'h020, '0);
    repeat (14) step();
    idle();
    repeat (3) step();

    // port 1 response backpressured while port 0 keeps writing
    rsp_ready = 2'b01;
    req_once(1, 1'b0, 12'h020, '0);
    drive(1, 1'b1, 1'b0, 12'h020, '0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b1, 1'b1, 12'h300 + 12'(i), 16'(16'h7000 + i));
      step();
    end
    rsp_ready = 2'b11;
    idle();
    repeat (4) step();

    // same-cycle write/read conflict with rr pointing at port 1
    req_once(1, 1'b1, 12'h042, 16'h1357);
    req_once(0, 1'b1, 12'h301, 16'h0000);
    drive(0, 1'b1, 1'b1, 12'h042, 16'hBEEF);
    drive(1, 1'b1, 1'b0, 12'h042, '0);
    step();
    step();
    idle();
    repeat (3) step();
    req_once(1, 1'b0, 12'h042, '0);
    repeat (4) step();

    // random traffic over a small address window to provoke hazards
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < 2; p++) begin
        drive(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              12'h200 + 12'($urandom_range(0, 7)), 16'($urandom));
        rsp_ready[p] = $urandom_range(0, 3) != 0;
      end
      step();
    end
    idle();
    rsp_ready = 2'b11;
    repeat (5) step();

    // reset while a read is in flight
    req_once(0, 1'b0, 12'h200, '0);
    chk_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ctrl", 32'({req_ready, rsp_valid, init_done, sram_csb, sram_web, sram_oeb}), 32'(8'b0000_0111));
    @(negedge clk);
    check_eq("midrst_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check_eq("resweep", 32'({rsp_valid, init_done, sram_csb, sram_web, sram_oeb, sram_a}),
               32'({2'b00, 1'b0, 3'b001, 12'(k)}));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram1rw_arbiter.md
Name: sram1rw_arbiter

Overview:
- Sequencer and two-requester arbiter for one single-port 4096x16 SRAM macro (CSB/WEB/OEB active-low, synchronous on the macro clock pin, 1-cycle registered read).
- After reset, sweeps the whole array to a known value, then time-shares the macro between two valid/ready requesters using round-robin priority.
- Writes are posted. Each read returns through a per-port response channel with backpressure.
- Sits between the cache/scratchpad clients and the macro; the macro clock pin is tied to clk at the parent.

Parameters:
- ADDR_W, 12, SRAM address width.
- DATA_W, 16, SRAM word width.
- DEPTH, 4096, number of words; must equal 2**ADDR_W.
- INIT_EN, 1, 1 = run the init sweep after reset; 0 = enter RUN directly.
- INIT_VAL, 16'h0000, word written to every address during the sweep.

Ports:
- clk  in  1  clock; also drives the macro clock pin.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-port request valid.
- req_ready  out  2  per-port request accepted this cycle.
- req_we  in  2  per port: 1 = write, 0 = read.
- req_addr  in  2*ADDR_W  per-port address; port p occupies bits [p*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  per-port write data.
- rsp_valid  out  2  per-port read data valid.
- rsp_ready  in  2  per-port response consumed.
- rsp_rdata  out  2*DATA_W  per-port read data, held while rsp_valid is high.
- init_done  out  1  high once the controller is in RUN.
- sram_csb, sram_web, sram_oeb  out  1 each  macro controls, active-low.
- sram_a  out  ADDR_W  macro address.
- sram_i  out  DATA_W  macro write data.
- sram_o  in  DATA_W  macro read data.

Behaviour:
- Reset values (asynchronous assertion): req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, sram_csb/web/oeb=1, sram_a=0, sram_i=0, rr=0.
- States: INIT -> RUN. Reset enters INIT if INIT_EN=1, otherwise RUN.

INIT:
- Counter icnt starts at 0.
- Each cycle: csb=0, web=0, oeb=1, a=icnt, i=INIT_VAL, then icnt++.
- After the cycle with icnt=DEPTH-1, go to RUN. The sweep takes exactly DEPTH cycles.
- req_ready=0 throughout. init_done=0 throughout.

RUN:
- init_done=1.
- Eligibility: port p is eligible iff req_valid[p] and either req_we[p]=1, or (rsp_valid[p]=0 and no read for p is in flight).
- Grant is combinational:
  - If one port is eligible, it wins.
  - If both are eligible, the port equal to rr wins.
  - On a grant, rr <= ~winner at the edge.
- req_ready[winner]=1 in the same cycle as the grant; the loser has req_ready=0.
- Macro drive in a grant cycle: csb=0, a=req_addr[w].
  - Write: web=0, oeb=1, i=req_wdata[w].
  - Read: web=1, oeb=0.
- No grant: csb=web=oeb=1. a and i hold their previous values.
- Read pipeline, for a read accepted at edge N:
  - The macro output is valid during cycle N+1.
  - At edge N+1: rsp_rdata[p] <= sram_o, rsp_valid[p] <= 1.
  - Read latency is 2 edges from accept to rsp_valid. The in-flight flag for p is set at edge N and cleared at edge N+1.
- Response handshake: rsp_valid[p] and rsp_rdata[p] hold until a cycle with rsp_ready[p]=1, which clears rsp_valid[p] at that edge.
  - A new read for p may not be accepted in the same cycle the old response pops; p regains eligibility the following cycle.
  - Per-port throughput is therefore one read every 3 cycles when rsp_ready is held high.
  - Writes are unaffected by response state.
- Ordering and hazards:
  - Single port: program order.
  - Cross-port: acceptance order. A read granted the cycle after a write to the same address returns the new data.
- Sustained throughput: one macro access per cycle when requests are eligible.
- Reset mid-operation: INIT restarts from address 0. In-flight reads and pending responses are discarded; no rsp_valid is produced for them.

Decomposition:
- Package sram_arb_pkg: state enum {ST_INIT, ST_RUN}, ADDR_W/DATA_W/DEPTH defaults, and a port-count constant NPORT=2.
- Sub-module rr_arb2 (two-way round-robin grant: eligible[1:0], rr, and grant-advance enable in; one-hot grant out) is natural and reused.
- Everything else stays in the top module.

Test Plan:
- Reset with INIT_EN=1, no requests -> init_done rises after exactly 4096 cycles. sram_web=0 for addresses 0..4095 in order. Reads to 0x000 and 0xFFF then return 16'h0000.
- Port0 writes 0xA5A5 to 0x123, then port0 reads 0x123 with rsp_ready=1 -> rsp_valid[0] two edges after the read accept, rsp_rdata[0]=0xA5A5, rsp_valid[0] high for 1 cycle.
- Both ports hold valid reads (p0 addr 0x010, p1 addr 0x020, preloaded 0x1111/0x2222) continuously, rr=0 -> grants alternate p0,p1,p0 subject to eligibility. Each port receives its own data; no cross-delivery.
- Port1 read done, rsp_ready[1]=0 for 5 cycles while req_valid[1]=1 -> req_ready[1]=0 and rsp_rdata[1] stable throughout. Port0 writes are still granted every cycle.
- Same-cycle conflict: p0 write 0x0042<-0xBEEF and p1 read 0x0042, rr=1 -> p1 is granted first and returns the old value; p0 is granted next. A second p1 read returns 0xBEEF.
- rst_n pulsed low while a read is in flight in RUN -> rsp_valid stays 0, all sram controls go to 1 immediately, init_done=0, and the sweep restarts from address 0.
